countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 118 +++++++++++
 tb/tb_countdown_timer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Millisecond countdown timer: a TICK_DIV-cycle prescaler drives a 32-bit
// down-counter through an IDLE/RUN/PAUSE/DONE state machine with registered outputs.
module countdown_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [31:0] remaining,
    output logic        running,
    output logic        done,
    output logic        expired
);

    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [31:0]          remaining_q, remaining_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 expired_q, expired_d;
    logic                 tick;

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        remaining_d = remaining_q;
        expired_d   = expired_q;
        done_d      = 1'b0;

        if (load) begin
            remaining_d = load_val;
            presc_d     = '0;
            expired_d   = 1'b0;
            state_d     = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && (remaining_q != 32'd0)) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    // A tick is never lost to a coincident pause; expiry outranks pause.
                    if (tick) begin
                        presc_d = '0;
                        if (remaining_q != 32'd0) begin
                            remaining_d = remaining_q - 32'd1;
                        end
                        if (remaining_q <= 32'd1) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                            done_d    = 1'b1;
                        end else if (pause) begin
                            state_d = PAUSE;
                        end
                    end else if (pause) begin
                        state_d = PAUSE;
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                PAUSE: begin
                    if (!pause && start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            remaining_q <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            running_q   <= running_d;
            done_q      <= done_d;
            expired_q   <= expired_d;
        end
    end

    assign remaining = remaining_q;
    assign running   = running_q;
    assign done      = done_q;
    assign expired   = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with TICK_DIV=4: directed scenarios plus random
// traffic, all compared against an elapsed-time reference model.
module tb_countdown_timer;

    localparam int TD = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] load_val = '0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [31:0] remaining;
    logic        running;
    logic        done;
    logic        expired;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: the count is derived from how many RUN cycles have elapsed since the load.
    longint m_loaded = 0;
    longint m_elapsed = 0;
    int     m_mode = M_IDLE;
    bit     m_done = 0;
    bit     m_exp = 0;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .remaining(remaining),
        .running(running), .done(done), .expired(expired)
    );

    always #5 clk = ~clk;

    function automatic longint m_rem();
        return m_loaded - (m_elapsed / TD);
    endfunction

    function automatic logic [34:0] m_vec();
        return {32'(m_rem()), (m_mode == M_RUN), m_done, m_exp};
    endfunction

    // Advance the model with the current inputs, then let the DUT take one edge.
    task automatic step();
        m_done = 0;
        if (rst) begin
            m_loaded = 0; m_elapsed = 0; m_mode = M_IDLE; m_exp = 0;
        end else if (load) begin
            m_loaded = load_val; m_elapsed = 0; m_mode = M_IDLE; m_exp = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (start && m_rem() != 0) m_mode = M_RUN;
                M_RUN: begin
                    if (pause && ((m_elapsed + 1) % TD) != 0) begin
                        m_mode = M_PAUSE;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == m_loaded * TD) begin
                            m_mode = M_DONE; m_done = 1; m_exp = 1;
                        end else if (pause) begin
                            m_mode = M_PAUSE;
                        end
                    end
                end
                M_PAUSE: if (!pause && start) m_mode = M_RUN;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic test_reset();
        rst = 1; load = 1; load_val = 32'd9; start = 1; pause = 0;
        step();
        idle_inputs();
        n_total++;
        if ({remaining, running, done, expired} !== 35'd0) begin
            $display("FAIL reset: got rem=%0d run=%b done=%b exp=%b want all 0",
                     remaining, running, done, expired);
        end else n_pass++;
    endtask

    task automatic test_basic();
        idle_inputs();
        load = 1; load_val = 32'd3; step();
        load = 0; start = 1; step();
        start = 0;
        for (int k = 1; k <= 13; k++) begin
            step();
            n_total++;
            if ({remaining, running, done, expired} !== m_vec()) begin
                $display("FAIL basic_model k=%0d: got %h want %h", k,
                         {remaining, running, done, expired}, m_vec());
            end else n_pass++;
            if (k % TD == 0 && k <= 12) begin
                n_total++;
                if (remaining !== 32'(3 - k / TD)) begin
                    $display("FAIL basic_step k=%0d: got %0d want %0d", k, remaining, 3 - k / TD);
                end else n_pass++;
            end
            if (k == 12) begin
                n_total++;
                if (!(done === 1'b1 && expired === 1'b1 && running === 1'b0)) begin
                    $display("FAIL basic_expiry: got done=%b exp=%b run=%b want 1 1 0",
                             done, expired, running);
                end else n_pass++;
            end
            if (k == 13) begin
                n_total++;
                if (!(done === 1'b0 && expired === 1'b1 && remaining === 32'd0)) begin
                    $display("FAIL basic_after: got done=%b exp=%b rem=%0d want 0 1 0",
                             done, expired, remaining);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_pause_resume();
        int run_edges;
        idle_inputs();
        load = 1; load_val = 32'd5; step();
        load = 0; start = 1; step();
        start = 0;
        for (int k = 1; k <= 6; k++) step();
        run_edges = 6;
        pause = 1; step();
        pause = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_total++;
            if (remaining !== 32'd4 || running !== 1'b0 || m_vec() !== {remaining, running, done, expired}) begin
                $display("FAIL pause_hold c=%0d: got rem=%0d run=%b want rem=4 run=0", k, remaining, running);
            end else n_pass++;
        end
        start = 1; step();
        start = 0;
        step(); run_edges++;
        n_total++;
        if (remaining !== 32'd4 || running !== 1'b1) begin
            $display("FAIL resume_1: got rem=%0d run=%b want 4 1", remaining, running);
        end else n_pass++;
        step(); run_edges++;
        n_total++;
        if (remaining !== 32'd3) begin
            $display("FAIL resume_2: got rem=%0d want 3", remaining);
        end else n_pass++;
        while (run_edges < 20) begin
            step(); run_edges++;
            n_total++;
            if ({remaining, running, done, expired} !== m_vec()) begin
                $display("FAIL pause_run e=%0d: got %h want %h", run_edges,
                         {remaining, running, done, expired}, m_vec());
            end else n_pass++;
        end
        n_total++;
        if (!(done === 1'b1 && remaining === 32'd0 && expired === 1'b1)) begin
            $display("FAIL pause_expiry: got done=%b rem=%0d exp=%b want 1 0 1", done, remaining, expired);
        end else n_pass++;
    endtask

    task automatic test_ignored_start();
        idle_inputs();
        rst = 1; step();
        rst = 0; start = 1; step();
        start = 0; step();
        n_total++;
        if (running !== 1'b0 || remaining !== 32'd0) begin
            $display("FAIL start_after_rst: got run=%b rem=%0d want 0 0", running, remaining);
        end else n_pass++;
        load = 1; load_val = 32'd0; step();
        load = 0; start = 1; step();
        start = 0;
        n_total++;
        if (running !== 1'b0) begin
            $display("FAIL start_zero: got run=%b want 0", running);
        end else n_pass++;
        load = 1; load_val = 32'd1; step();
        load = 0; start = 1; step();
        start = 0;
        for (int k = 0; k < TD; k++) step();
        start = 1; step(); step();
        start = 0;
        n_total++;
        if (!(running === 1'b0 && expired === 1'b1 && remaining === 32'd0 && done === 1'b0)) begin
            $display("FAIL start_in_done: got run=%b exp=%b rem=%0d done=%b want 0 1 0 0",
                     running, expired, remaining, done);
        end else n_pass++;
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        load = 1; load_val = 32'd1; step();
        load = 0; start = 1; step();
        start = 0;
        for (int k = 1; k < TD; k++) step();
        load = 1; load_val = 32'd7; step();
        load = 0;
        n_total++;
        if (!(remaining === 32'd7 && running === 1'b0 && done === 1'b0 && expired === 1'b0)) begin
            $display("FAIL load_on_expiry: got rem=%0d run=%b done=%b exp=%b want 7 0 0 0",
                     remaining, running, done, expired);
        end else n_pass++;
        step();
        n_total++;
        if (done !== 1'b0 || expired !== 1'b0) begin
            $display("FAIL load_on_expiry_late: got done=%b exp=%b want 0 0", done, expired);
        end else n_pass++;
        start = 1; step();
        start = 0; step();
        start = 1; pause = 1; step();
        n_total++;
        if (running !== 1'b0 || {remaining, running, done, expired} !== m_vec()) begin
            $display("FAIL start_pause_run: got run=%b want 0", running);
        end else n_pass++;
        step();
        n_total++;
        if (running !== 1'b0) begin
            $display("FAIL start_pause_paused: got run=%b want 0", running);
        end else n_pass++;
        pause = 0; step();
        start = 0;
        n_total++;
        if (running !== 1'b1) begin
            $display("FAIL resume_after_both: got run=%b want 1", running);
        end else n_pass++;
        load = 1; load_val = 32'd1; step();
        load = 0; start = 1; step();
        start = 0;
        for (int k = 1; k < TD; k++) step();
        pause = 1; step();
        pause = 0;
        n_total++;
        if (!(done === 1'b1 && expired === 1'b1 && running === 1'b0 && remaining === 32'd0)) begin
            $display("FAIL pause_on_final_tick: got done=%b exp=%b run=%b rem=%0d want 1 1 0 0",
                     done, expired, running, remaining);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        idle_inputs();
        load = 1; load_val = 32'd100; step();
        load = 0; start = 1; step();
        start = 0;
        for (int k = 1; k < 10; k++) step();
        rst = 1; step();
        rst = 0;
        n_total++;
        if ({remaining, running, done, expired} !== 35'd0) begin
            $display("FAIL rst_mid_run: got rem=%0d run=%b done=%b exp=%b want all 0",
                     remaining, running, done, expired);
        end else n_pass++;
        start = 1; step();
        start = 0;
        for (int k = 0; k < 2 * TD; k++) begin
            step();
            n_total++;
            if ({remaining, running, done, expired} !== 35'd0) begin
                $display("FAIL rst_then_start c=%0d: got rem=%0d run=%b done=%b want 0 0 0",
                         k, remaining, running, done);
            end else n_pass++;
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            load     = ($urandom_range(0, 39) == 0);
            load_val = 32'($urandom_range(0, 5));
            start    = ($urandom_range(0, 3) == 0);
            pause    = ($urandom_range(0, 7) == 0);
            step();
            n_total++;
            if ({remaining, running, done, expired} !== m_vec()) begin
                $display("FAIL random c=%0d: got rem=%0d run=%b done=%b exp=%b want rem=%0d run=%b done=%b exp=%b",
                         c, remaining, running, done, expired, m_rem(), (m_mode == M_RUN), m_done, m_exp);
            end else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause_resume();
        test_ignored_start();
        test_simultaneous();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
